// File: rtl/connect_n_pkg.sv
// Shared types for the Connect-N engine: FSM states,
// scan directions and their (dc, dr) step table.
package connect_n_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PLACE,
    ST_SCAN,
    ST_DECIDE,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_UP,
    DIR_DN
  } dir_e;

  typedef struct packed {
    logic signed [1:0] dc;
    logic signed [1:0] dr;
  } delta_t;

  localparam int CELL_EMPTY = 0;

  // Positive-side step of each line; the negative side walks -delta
  function automatic delta_t dir_delta(input dir_e d);
    delta_t r;
    r.dc = 2'b01;
    r.dr = 2'b00;
    case (d)
      DIR_H:   begin r.dc = 2'b01; r.dr = 2'b00; end
      DIR_V:   begin r.dc = 2'b00; r.dr = 2'b01; end
      DIR_UP:  begin r.dc = 2'b01; r.dr = 2'b01; end
      DIR_DN:  begin r.dc = 2'b01; r.dr = 2'b11; end
      default: begin r.dc = 2'b01; r.dr = 2'b00; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/connect_n_engine_scanner.sv
// cn_line_scanner: walks one line through the start cell, one
// probe per cycle, negative side first, and flags a win.
module cn_line_scanner
  import connect_n_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4,
  parameter int PLAYERS = 2,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS + 1),
  localparam int PL_W   = $clog2(PLAYERS + 1),
  localparam int PW     = ((COL_W > ROW_W) ? COL_W : ROW_W) + 2,
  localparam int CW     = $clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [COL_W-1:0] start_col,
  input  logic [ROW_W-1:0] start_row,
  input  dir_e             dir,
  input  logic [PL_W-1:0]  player,
  input  logic [PL_W-1:0]  probe_cell,
  output logic [COL_W-1:0] probe_col,
  output logic [ROW_W-1:0] probe_row,
  output logic             hit,
  output logic             done
);

  logic signed [PW-1:0] pos_c_q, pos_c_d;
  logic signed [PW-1:0] pos_r_q, pos_r_d;
  logic signed [PW-1:0] st_c_q, st_c_d;
  logic signed [PW-1:0] st_r_q, st_r_d;
  logic signed [PW-1:0] dc_w, dr_w;
  logic signed [PW-1:0] dc_in, dr_in;
  logic signed [PW-1:0] new_c, new_r;
  logic                 side_q, side_d;
  logic                 busy_q, busy_d;
  dir_e                 dir_q, dir_d;
  logic [PL_W-1:0]      ply_q, ply_d;
  logic [CW-1:0]        steps_q, steps_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 in_range;
  logic                 match;
  delta_t               dl, dl_in;

  assign probe_col = pos_c_q[COL_W-1:0];
  assign probe_row = pos_r_q[ROW_W-1:0];

  always_comb begin
    dl       = dir_delta(dir_q);
    dl_in    = dir_delta(dir);
    dc_w     = {{(PW-2){dl.dc[1]}}, dl.dc};
    dr_w     = {{(PW-2){dl.dr[1]}}, dl.dr};
    dc_in    = {{(PW-2){dl_in.dc[1]}}, dl_in.dc};
    dr_in    = {{(PW-2){dl_in.dr[1]}}, dl_in.dr};
    new_c    = {{(PW-COL_W){1'b0}}, start_col};
    new_r    = {{(PW-ROW_W){1'b0}}, start_row};
    in_range = !pos_c_q[PW-1] && !pos_r_q[PW-1]
            && (pos_c_q < PW'(COLS))
            && (pos_r_q < PW'(ROWS));
    match    = busy_q && in_range
            && (probe_cell == ply_q)
            && (steps_q < CW'(WIN_LEN - 1));
    hit      = match && (count_q == CW'(WIN_LEN - 1));
    done     = busy_q && (hit || (!match && side_q));

    pos_c_d = pos_c_q;
    pos_r_d = pos_r_q;
    st_c_d  = st_c_q;
    st_r_d  = st_r_q;
    side_d  = side_q;
    busy_d  = busy_q;
    dir_d   = dir_q;
    ply_d   = ply_q;
    steps_d = steps_q;
    count_d = count_q;

    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d  = 1'b1;
      side_d  = 1'b0;
      steps_d = '0;
      count_d = CW'(1);
      st_c_d  = new_c;
      st_r_d  = new_r;
      pos_c_d = new_c - dc_in;
      pos_r_d = new_r - dr_in;
      dir_d   = dir;
      ply_d   = player;
    end else if (busy_q) begin
      if (hit) begin
        busy_d = 1'b0;
      end else if (match) begin
        count_d = count_q + CW'(1);
        steps_d = steps_q + CW'(1);
        pos_c_d = side_q ? pos_c_q + dc_w : pos_c_q - dc_w;
        pos_r_d = side_q ? pos_r_q + dr_w : pos_r_q - dr_w;
      end else if (!side_q) begin
        side_d  = 1'b1;
        steps_d = '0;
        pos_c_d = st_c_q + dc_w;
        pos_r_d = st_r_q + dr_w;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_c_q <= '0;
      pos_r_q <= '0;
      st_c_q  <= '0;
      st_r_q  <= '0;
      side_q  <= 1'b0;
      busy_q  <= 1'b0;
      dir_q   <= DIR_H;
      ply_q   <= '0;
      steps_q <= '0;
      count_q <= '0;
    end else begin
      pos_c_q <= pos_c_d;
      pos_r_q <= pos_r_d;
      st_c_q  <= st_c_d;
      st_r_q  <= st_r_d;
      side_q  <= side_d;
      busy_q  <= busy_d;
      dir_q   <= dir_d;
      ply_q   <= ply_d;
      steps_q <= steps_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game core: move handshake, token drop, multi-cycle
// win/draw scan. Define CN_UNDO_EN for the undo_req history stack.
module connect_n_engine
  import connect_n_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4,
  parameter int PLAYERS = 2,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS + 1),
  localparam int PL_W   = $clog2(PLAYERS + 1),
  localparam int CELLS  = COLS * ROWS,
  localparam int MV_W   = $clog2(CELLS + 1)
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             new_game,
  input  logic             move_req,
  input  logic [COL_W-1:0] move_col,
  output logic             move_ready,
  output logic             move_done,
  output logic             move_reject,
  output logic [PL_W-1:0]  cur_player,
  output logic             game_over,
  output logic [PL_W-1:0]  winner,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
`ifdef CN_UNDO_EN
  input  logic             undo_req,
`endif
  output logic [PL_W-1:0]  rd_cell
);

  typedef logic [COLS-1:0][ROWS-1:0][PL_W-1:0] board_t;
  typedef logic [COLS-1:0][ROW_W-1:0]          height_t;

  state_e           state_q, state_d;
  board_t           board_q, board_d;
  height_t          height_q, height_d;
  logic [MV_W-1:0]  moves_q, moves_d;
  logic [PL_W-1:0]  cur_q, cur_d;
  logic [PL_W-1:0]  win_q, win_d;
  logic             over_q, over_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             hit_q, hit_d;
  logic [COL_W-1:0] mcol_q, mcol_d;
  logic [ROW_W-1:0] mrow_q, mrow_d;
  dir_e             dir_q, dir_d;
  logic             scan_start;
  logic             scan_hit;
  logic             scan_done;
  logic [COL_W-1:0] probe_col;
  logic [ROW_W-1:0] probe_row;
  logic [PL_W-1:0]  probe_cell;
  logic             col_bad;

`ifdef CN_UNDO_EN
  logic [CELLS-1:0][COL_W-1:0] hist_q, hist_d;
  logic [COL_W-1:0]            ucol;
  logic [ROW_W-1:0]            urow;

  // In OVER the turn was never advanced, so the last mover is cur_q
  function automatic logic [PL_W-1:0] prev_player(
    input logic [PL_W-1:0] p
  );
    return (p == PL_W'(1)) ? PL_W'(PLAYERS) : p - PL_W'(1);
  endfunction
`endif

  function automatic logic [PL_W-1:0] next_player(
    input logic [PL_W-1:0] p
  );
    return (p == PL_W'(PLAYERS)) ? PL_W'(1) : p + PL_W'(1);
  endfunction

  assign move_ready  = (state_q == ST_WAIT);
  assign move_done   = done_q;
  assign move_reject = rej_q;
  assign cur_player  = cur_q;
  assign game_over   = over_q;
  assign winner      = win_q;

  assign rd_cell = ((32'(rd_col) < COLS) && (32'(rd_row) < ROWS))
                 ? board_q[rd_col][rd_row] : PL_W'(CELL_EMPTY);

  assign probe_cell =
    ((32'(probe_col) < COLS) && (32'(probe_row) < ROWS))
    ? board_q[probe_col][probe_row] : PL_W'(CELL_EMPTY);

  cn_line_scanner #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .WIN_LEN (WIN_LEN),
    .PLAYERS (PLAYERS)
  ) u_scan (
    .clk        (CLOCK_50),
    .rst        (Reset),
    .start      (scan_start),
    .abort      (new_game),
    .start_col  (mcol_q),
    .start_row  (mrow_q),
    .dir        (dir_d),
    .player     (cur_q),
    .probe_cell (probe_cell),
    .probe_col  (probe_col),
    .probe_row  (probe_row),
    .hit        (scan_hit),
    .done       (scan_done)
  );

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    height_d   = height_q;
    moves_d    = moves_q;
    cur_d      = cur_q;
    win_d      = win_q;
    over_d     = over_q;
    done_d     = 1'b0;
    rej_d      = 1'b0;
    hit_d      = hit_q;
    mcol_d     = mcol_q;
    mrow_d     = mrow_q;
    dir_d      = dir_q;
    scan_start = 1'b0;
    col_bad    = (32'(move_col) >= COLS)
              || (height_q[move_col] == ROW_W'(ROWS));
`ifdef CN_UNDO_EN
    hist_d = hist_q;
    ucol   = '0;
    urow   = '0;
`endif
    if (new_game) begin
      board_d  = '0;
      height_d = '0;
      moves_d  = '0;
      state_d  = ST_WAIT;
      cur_d    = PL_W'(1);
      win_d    = '0;
      over_d   = 1'b0;
      hit_d    = 1'b0;
    end
`ifdef CN_UNDO_EN
    else if (undo_req &&
             (state_q == ST_WAIT || state_q == ST_OVER)) begin
      if (moves_q == '0) begin
        rej_d = 1'b1;
      end else begin
        ucol    = hist_q[moves_q - MV_W'(1)];
        urow    = height_q[ucol] - ROW_W'(1);
        board_d[ucol][urow] = PL_W'(CELL_EMPTY);
        height_d[ucol] = urow;
        moves_d = moves_q - MV_W'(1);
        if (state_q == ST_WAIT) cur_d = prev_player(cur_q);
        over_d  = 1'b0;
        win_d   = '0;
        state_d = ST_WAIT;
      end
    end
`endif
    else begin
      unique case (state_q)
        ST_WAIT: begin
          if (move_req) begin
            if (col_bad) begin
              rej_d = 1'b1;
            end else begin
              mcol_d  = move_col;
              mrow_d  = height_q[move_col];
              hit_d   = 1'b0;
              state_d = ST_PLACE;
            end
          end
        end
        ST_PLACE: begin
          board_d[mcol_q][mrow_q] = cur_q;
          height_d[mcol_q] = mrow_q + ROW_W'(1);
          moves_d    = moves_q + MV_W'(1);
`ifdef CN_UNDO_EN
          hist_d[moves_q] = mcol_q;
`endif
          dir_d      = DIR_H;
          scan_start = 1'b1;
          state_d    = ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_hit) begin
            hit_d   = 1'b1;
            state_d = ST_DECIDE;
          end else if (scan_done) begin
            if (dir_q == DIR_DN) begin
              state_d = ST_DECIDE;
            end else begin
              dir_d      = dir_e'(dir_q + 2'd1);
              scan_start = 1'b1;
            end
          end
        end
        ST_DECIDE: begin
          done_d = 1'b1;
          if (hit_q) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
            win_d   = cur_q;
          end else if (moves_q == MV_W'(CELLS)) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
            win_d   = '0;
          end else begin
            cur_d   = next_player(cur_q);
            state_d = ST_WAIT;
          end
        end
        ST_OVER: begin
          if (move_req) rej_d = 1'b1;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_WAIT;
      board_q  <= '0;
      height_q <= '0;
      moves_q  <= '0;
      cur_q    <= PL_W'(1);
      win_q    <= '0;
      over_q   <= 1'b0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      hit_q    <= 1'b0;
      mcol_q   <= '0;
      mrow_q   <= '0;
      dir_q    <= DIR_H;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      height_q <= height_d;
      moves_q  <= moves_d;
      cur_q    <= cur_d;
      win_q    <= win_d;
      over_q   <= over_d;
      done_q   <= done_d;
      rej_q    <= rej_d;
      hit_q    <= hit_d;
      mcol_q   <= mcol_d;
      mrow_q   <= mrow_d;
      dir_q    <= dir_d;
    end
  end

`ifdef CN_UNDO_EN
  always_ff @(posedge CLOCK_50) begin
    hist_q <= hist_d;
  end
`endif

endmodule
